// File: rtl/addsub_pkg.sv
// Shared types and constants for the serial nibble add/subtract engine.
//   state_t      : engine FSM states
//   NIB_W        : datapath slice width (one nibble)
//   sat_max/min  : saturation limits for a w-bit two's-complement word
package addsub_pkg;

    localparam int unsigned NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Largest positive w-bit value, 0x7F..F, zero-extended to 64 bits.
    function automatic logic [63:0] sat_max(input int unsigned w);
        logic [63:0] one;
        one = 64'd1;
        return (one << (w - 1)) - one;
    endfunction

    // Most negative w-bit value, 0x80..0, zero-extended to 64 bits.
    function automatic logic [63:0] sat_min(input int unsigned w);
        logic [63:0] one;
        one = 64'd1;
        return one << (w - 1);
    endfunction

endpackage

// File: rtl/serial_nibble_addsub_adder.sv
// 4-bit ripple-carry adder; the only arithmetic in the engine.
// Ports:
//   a, b : nibble operands (b arrives pre-inverted for subtraction)
//   cin  : carry in
//   sum  : 4-bit sum
//   cout : carry out of bit 3
//   v    : signed overflow (carry into bit 3 differs from carry out)
module serial_nibble_addsub_adder
    import addsub_pkg::*;
(
    output logic [NIB_W-1:0] sum,
    output logic             cout,
    output logic             v,
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             cin
);

    logic [NIB_W:0] c;

    // Ripple chain of full adders.
    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < int'(NIB_W); i++) begin
            sum[i]  = a[i] ^ b[i] ^ c[i];
            c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = c[NIB_W];
    assign v    = c[NIB_W] ^ c[NIB_W-1];

endmodule

// File: rtl/serial_nibble_addsub.sv
// Multi-nibble add/subtract engine: processes one nibble per cycle, LSB
// first, through a single 4-bit adder, with a carry register between nibbles.
// Optional build macro: ADDSUB_SATURATE_EN clamps the result on overflow.
// Ports:
//   clk, rst                : clock, async active-high reset
//   start_valid/start_ready : operand handshake (ready = engine idle)
//   op_a, op_b, sub         : operands and mode (0: A+B, 1: A-B)
//   res_valid/res_ready     : result handshake
//   result, carry, overflow, zero : registered result and flags
module serial_nibble_addsub
    import addsub_pkg::*;
#(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_valid,
    output logic                     start_ready,
    input  logic [NIB_W*NIBBLES-1:0] op_a,
    input  logic [NIB_W*NIBBLES-1:0] op_b,
    input  logic                     sub,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [NIB_W*NIBBLES-1:0] result,
    output logic                     carry,
    output logic                     overflow,
    output logic                     zero
);

    localparam int unsigned W     = NIB_W * NIBBLES;
    localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t           state, state_d;
    logic [IDX_W-1:0] idx, idx_d;
    logic             cr, cr_d;
    logic [W-1:0]     a_q, a_d, b_q, b_d;
    logic             sub_q, sub_d;
    logic [W-1:0]     result_d;
    logic             carry_d, overflow_d, zero_d;
    logic             start_ready_d, res_valid_d;

    logic [NIB_W-1:0] nib_a, nib_b, nib_sum;
    logic             nib_cout, nib_v;

    // Current nibble slice; subtraction inverts B and seeds the carry with 1.
    assign nib_a = a_q[idx*NIB_W +: NIB_W];
    assign nib_b = b_q[idx*NIB_W +: NIB_W] ^ {NIB_W{sub_q}};

    serial_nibble_addsub_adder u_adder (
        .sum  (nib_sum),
        .cout (nib_cout),
        .v    (nib_v),
        .a    (nib_a),
        .b    (nib_b),
        .cin  (cr)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state;
        idx_d      = idx;
        cr_d       = cr;
        a_d        = a_q;
        b_d        = b_q;
        sub_d      = sub_q;
        result_d   = result;
        carry_d    = carry;
        overflow_d = overflow;
        zero_d     = zero;

        unique case (state)
            IDLE: begin
                if (start_valid) begin
                    a_d        = op_a;
                    b_d        = op_b;
                    sub_d      = sub;
                    idx_d      = '0;
                    cr_d       = sub;
                    result_d   = '0;
                    carry_d    = 1'b0;
                    overflow_d = 1'b0;
                    zero_d     = 1'b0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                result_d[idx*NIB_W +: NIB_W] = nib_sum;
                cr_d = nib_cout;
                if (idx == LAST_IDX) begin
                    carry_d    = nib_cout;
                    overflow_d = nib_v;
`ifdef ADDSUB_SATURATE_EN
                    // Sign of A gives the sign of the true (unwrapped) result.
                    if (nib_v) begin
                        result_d = a_q[W-1] ? W'(sat_min(W)) : W'(sat_max(W));
                    end
`endif
                    zero_d  = ~|result_d;
                    state_d = DONE;
                end else begin
                    idx_d = idx + 1'b1;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        start_ready_d = (state_d == IDLE);
        res_valid_d   = (state_d == DONE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            cr          <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sub_q       <= 1'b0;
            result      <= '0;
            carry       <= 1'b0;
            overflow    <= 1'b0;
            zero        <= 1'b0;
            start_ready <= 1'b1;
            res_valid   <= 1'b0;
        end else begin
            state       <= state_d;
            idx         <= idx_d;
            cr          <= cr_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sub_q       <= sub_d;
            result      <= result_d;
            carry       <= carry_d;
            overflow    <= overflow_d;
            zero        <= zero_d;
            start_ready <= start_ready_d;
            res_valid   <= res_valid_d;
        end
    end

endmodule
